cic_decimator_var: RTL and testbench

Parametrised, runtime-programmable CIC decimator, successor to the fixed-ratio CIC in the receive chain. It generates its own decimation strobe from an input-sample enable, so no external rate clock is needed. Decimation ratio is a power of two selected at run time. Output is gain-normalised, rounded and saturated to a narrower word. It sits between the NCO mixer output and the compensating FIR.

---
 rtl/cic_pkg.sv | 29 ++
 rtl/cic_round_sat.sv | 60 ++++++
 rtl/cic_decimator_var.sv | 145 ++++++++++++++
 tb/tb_cic_decimator_var.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared helpers for the runtime-programmable CIC decimator.
//   calc_asz     : accumulator width ISZ + N*MAX_RATE_LOG2
//   clamp_rate   : maps a raw rate exponent onto the legal range 1..max
//   out_shift    : output normalisation shift s(k) = ISZ - OSZ + N*k
//   warmup_count : number of suppressed strobes after reset / rate change
package cic_pkg;

    // Strobes beyond the comb depth that are discarded while the combs flush.
    localparam int WARMUP_EXTRA = 2;

    function automatic int calc_asz(input int isz, input int n, input int max_rate_log2);
        return isz + n * max_rate_log2;
    endfunction

    function automatic int clamp_rate(input int raw, input int max_rate_log2);
        if (raw == 0) return 1;
        if (raw > max_rate_log2) return max_rate_log2;
        return raw;
    endfunction

    function automatic int out_shift(input int isz, input int osz, input int n, input int k);
        return isz - osz + n * k;
    endfunction

    function automatic int warmup_count(input int n);
        return n + WARMUP_EXTRA;
    endfunction

endpackage

// File: rtl/cic_round_sat.sv
// Output normalisation stage: round half-up by 2^(shift-1), arithmetic shift
// right, saturate to OSZ bits, register.
//   clk, reset : clock, synchronous active-low reset
//   flush      : suppresses a pending strobe; out holds
//   strobe     : value is a fresh comb result this cycle
//   value      : ASZ-bit comb output
//   shift      : normalisation shift s
//   out        : registered rounded/saturated sample (held between strobes)
//   out_valid  : one-cycle pulse per new sample
module cic_round_sat #(
    parameter int ASZ = 36,
    parameter int OSZ = 16,
    parameter int SW  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  strobe,
    input  logic signed [ASZ-1:0] value,
    input  logic [SW-1:0]         shift,
    output logic signed [OSZ-1:0] out,
    output logic                  out_valid
);
    // One guard bit so the rounding add cannot wrap.
    localparam int EW = ASZ + 1;
    localparam logic signed [EW-1:0] OMAX = EW'((2 ** (OSZ - 1)) - 1);
    localparam logic signed [EW-1:0] OMIN = ~OMAX;

    logic signed [EW-1:0]  rnd, sum, shifted, sat;
    logic signed [OSZ-1:0] out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  emit;

    always_comb begin
        // 2^(s-1) for s>0, 0 for s=0.
        rnd     = (EW'(1) << shift) >> 1;
        sum     = EW'(value) + rnd;
        shifted = sum >>> shift;
        if (shifted > OMAX)      sat = OMAX;
        else if (shifted < OMIN) sat = OMIN;
        else                     sat = shifted;
        emit        = strobe && !flush;
        out_valid_d = emit;
        out_d       = emit ? sat[OSZ-1:0] : out_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: rtl/cic_decimator_var.sv
// Runtime-programmable CIC decimator, ratio R = 2^k, k = clamped rate_log2.
//   clk, reset : clock, synchronous active-low reset
//   in         : ISZ-bit signed sample, qualified by in_valid
//   rate_log2  : decimation exponent (0 -> 1, above MAX_RATE_LOG2 -> max)
//   out        : OSZ-bit gain-normalised sample, held between pulses
//   out_valid  : single-cycle pulse per output sample
//   rate_err   : registered flag, rate_log2 outside 1..MAX_RATE_LOG2
// Integrators advance on accepted samples only; a decimation strobe latches
// the last integrator and walks one comb stage per clock, then the output
// stage rounds/saturates. A change of clamped rate clears the filter state.
module cic_decimator_var
    import cic_pkg::*;
#(
    parameter  int ISZ           = 16,
    parameter  int OSZ           = 16,
    parameter  int NUM_STAGES    = 4,
    parameter  int MAX_RATE_LOG2 = 5,
    localparam int RW            = $clog2(MAX_RATE_LOG2 + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [ISZ-1:0] in,
    input  logic                  in_valid,
    input  logic [RW-1:0]         rate_log2,
    output logic signed [OSZ-1:0] out,
    output logic                  out_valid,
    output logic                  rate_err
);
    localparam int N    = NUM_STAGES;
    localparam int ASZ  = calc_asz(ISZ, NUM_STAGES, MAX_RATE_LOG2);
    localparam int CW   = MAX_RATE_LOG2;
    localparam int WARM = warmup_count(NUM_STAGES);
    localparam int WW   = $clog2(WARM + 1);
    localparam int SW   = $clog2(out_shift(ISZ, OSZ, NUM_STAGES, MAX_RATE_LOG2) + 1);

    logic [RW-1:0]         k_q, k_d;
    logic                  rate_err_q, rate_err_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_max;
    logic [WW-1:0]         warm_q, warm_d;
    logic [N-1:0][ASZ-1:0] integ_q, integ_d, comb_q, comb_d, dly_q, dly_d;
    logic [ASZ-1:0]        cap_q, cap_d, in_ext;
    logic [N:0]            vld_pipe_q, vld_pipe_d, emit_pipe_q, emit_pipe_d;
    logic                  rate_chg, accept, dec, emit;
    logic [SW-1:0]         shift;

    always_comb begin
        k_d        = RW'(clamp_rate(int'(rate_log2), MAX_RATE_LOG2));
        rate_err_d = (rate_log2 == '0) || (int'(rate_log2) > MAX_RATE_LOG2);
        rate_chg   = (k_d != k_q);
        // A sample arriving with a rate change is dropped.
        accept     = in_valid && !rate_chg;
        cnt_max    = {CW{1'b1}} >> (RW'(MAX_RATE_LOG2) - k_q);
        dec        = accept && (cnt_q == cnt_max);
        emit       = dec && (warm_q == WW'(WARM));
        in_ext     = ASZ'(in);

        integ_d     = integ_q;
        cnt_d       = cnt_q;
        warm_d      = warm_q;
        cap_d       = cap_q;
        comb_d      = comb_q;
        dly_d       = dly_q;
        vld_pipe_d  = {vld_pipe_q[N-1:0], dec};
        emit_pipe_d = {emit_pipe_q[N-1:0], emit};

        if (accept) begin
            integ_d[0] = integ_q[0] + in_ext;
            for (int i = 1; i < N; i++) integ_d[i] = integ_q[i] + integ_q[i-1];
            cnt_d = dec ? '0 : cnt_q + 1'b1;
        end

        if (dec) begin
            cap_d = integ_q[N-1];
            if (warm_q != WW'(WARM)) warm_d = warm_q + 1'b1;
        end

        // Comb stage i fires one clock after stage i-1 (differential delay 1).
        if (vld_pipe_q[0]) begin
            comb_d[0] = cap_q - dly_q[0];
            dly_d[0]  = cap_q;
        end
        for (int i = 1; i < N; i++) begin
            if (vld_pipe_q[i]) begin
                comb_d[i] = comb_q[i-1] - dly_q[i];
                dly_d[i]  = comb_q[i-1];
            end
        end

        if (rate_chg) begin
            integ_d     = '0;
            cnt_d       = '0;
            warm_d      = '0;
            cap_d       = '0;
            comb_d      = '0;
            dly_d       = '0;
            vld_pipe_d  = '0;
            emit_pipe_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            k_q         <= k_d;
            rate_err_q  <= 1'b0;
            cnt_q       <= '0;
            warm_q      <= '0;
            integ_q     <= '0;
            cap_q       <= '0;
            comb_q      <= '0;
            dly_q       <= '0;
            vld_pipe_q  <= '0;
            emit_pipe_q <= '0;
        end else begin
            k_q         <= k_d;
            rate_err_q  <= rate_err_d;
            cnt_q       <= cnt_d;
            warm_q      <= warm_d;
            integ_q     <= integ_d;
            cap_q       <= cap_d;
            comb_q      <= comb_d;
            dly_q       <= dly_d;
            vld_pipe_q  <= vld_pipe_d;
            emit_pipe_q <= emit_pipe_d;
        end
    end

    assign shift    = SW'(out_shift(ISZ, OSZ, NUM_STAGES, int'(k_q)));
    assign rate_err = rate_err_q;

    cic_round_sat #(
        .ASZ (ASZ),
        .OSZ (OSZ),
        .SW  (SW)
    ) u_round_sat (
        .clk       (clk),
        .reset     (reset),
        .flush     (rate_chg),
        .strobe    (emit_pipe_q[N]),
        .value     (comb_q[N-1]),
        .shift     (shift),
        .out       (out),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_cic_decimator_var.sv
// Bench for cic_decimator_var: two instances (OSZ=16 and OSZ=12) share the
// stimulus. The reference treats the CIC as an N-fold boxcar FIR of length R
// evaluated at every R-th accepted sample, then rounds and saturates.
module tb_cic_decimator_var;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic signed [15:0] din;
    logic               in_valid;
    logic [2:0]         rate_log2;
    logic signed [15:0] out_a;
    logic               vld_a, err_a;
    logic signed [11:0] out_b;
    logic               vld_b, err_b;

    int checks = 0;
    int failures = 0;

    cic_decimator_var #(.ISZ(16), .OSZ(16), .NUM_STAGES(N), .MAX_RATE_LOG2(5)) dut_a (
        .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .rate_log2(rate_log2),
        .out(out_a), .out_valid(vld_a), .rate_err(err_a));

    cic_decimator_var #(.ISZ(16), .OSZ(12), .NUM_STAGES(N), .MAX_RATE_LOG2(5)) dut_b (
        .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .rate_log2(rate_log2),
        .out(out_b), .out_valid(vld_b), .rate_err(err_b));

    // ---------------- reference model ----------------
    typedef struct { int due; longint a; longint b; } pend_t;
    pend_t  pend[$];
    longint xs[$];
    longint hcur[0:127];
    int     hlen;
    int     k_m;
    int     strobes;
    int     cyc = 0;
    bit     armed = 1'b0;
    logic   exp_valid = 1'b0;
    longint exp_a = 0, exp_b = 0;
    logic   exp_err = 1'b0;
    int     pulse_cnt = 0;

    function automatic int clampk(input logic [2:0] r);
        if (r == 3'd0) return 1;
        if (r > 3'd5) return 5;
        return int'(r);
    endfunction

    // Impulse response of N cascaded length-R boxcars.
    function automatic void set_h(input int k);
        longint t[0:127];
        int r;
        r = 1 << k;
        for (int j = 0; j < 128; j++) hcur[j] = 0;
        hcur[0] = 1;
        hlen = 1;
        for (int st = 0; st < N; st++) begin
            for (int j = 0; j < hlen + r - 1; j++) begin
                t[j] = 0;
                for (int i = 0; i < r; i++)
                    if (j - i >= 0 && j - i < hlen) t[j] += hcur[j-i];
            end
            hlen += r - 1;
            for (int j = 0; j < hlen; j++) hcur[j] = t[j];
        end
    endfunction

    // Filter output for the strobe at accepted-sample index n; the integrator
    // chain lags the input by N samples.
    function automatic longint cic_out(input int n);
        longint y;
        y = 0;
        for (int j = 0; j < hlen; j++) begin
            int idx;
            idx = n - N - j;
            if (idx >= 0) y += hcur[j] * xs[idx];
        end
        return y;
    endfunction

    function automatic longint rs(input longint y, input int k, input int osz);
        int s;
        longint v, hi;
        s  = 16 - osz + N * k;
        hi = (64'sd1 <<< (osz - 1)) - 1;
        v  = y;
        if (s > 0) v += 64'sd1 <<< (s - 1);
        v = v >>> s;
        if (v > hi) v = hi;
        if (v < -hi - 1) v = -hi - 1;
        return v;
    endfunction

    initial begin
        forever begin
            int kc, n, r;
            longint y;
            @(posedge clk);
            cyc++;
            kc = clampk(rate_log2);
            if (!reset) begin
                k_m = kc; set_h(k_m);
                xs.delete(); pend.delete(); strobes = 0;
                exp_valid = 1'b0; exp_a = 0; exp_b = 0; exp_err = 1'b0;
                armed = 1'b1;
            end else begin
                exp_err   = (rate_log2 == 3'd0) || (rate_log2 > 3'd5);
                exp_valid = 1'b0;
                if (kc != k_m) begin
                    k_m = kc; set_h(k_m);
                    xs.delete(); pend.delete(); strobes = 0;
                end else begin
                    if (pend.size() > 0 && pend[0].due == cyc) begin
                        exp_valid = 1'b1;
                        exp_a = pend[0].a;
                        exp_b = pend[0].b;
                        void'(pend.pop_front());
                    end
                    if (in_valid) begin
                        xs.push_back(longint'(din));
                        n = xs.size() - 1;
                        r = 1 << k_m;
                        if (n % r == r - 1) begin
                            strobes++;
                            if (strobes > N + 2) begin
                                y = cic_out(n);
                                pend.push_back('{cyc + N + 1, rs(y, k_m, 16), rs(y, k_m, 12)});
                            end
                        end
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_lit(input string nm, input logic signed [63:0] dutv,
                           input logic signed [63:0] modv, input logic signed [63:0] lit);
        chk({nm, "_dut"}, dutv, lit);
        chk({nm, "_model"}, modv, lit);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("out_valid_a", vld_a, exp_valid);
                chk("out_valid_b", vld_b, exp_valid);
                chk("out_a", out_a, exp_a);
                chk("out_b", out_b, exp_b);
                chk("rate_err_a", err_a, exp_err);
                chk("rate_err_b", err_b, exp_err);
                if (vld_a) pulse_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] r);
        reset = 1'b0; rate_log2 = r; in_valid = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic feed(input int ncyc, input int val, input int duty, input bit rnd);
        for (int c = 0; c < ncyc; c++) begin
            in_valid = (int'($urandom_range(99)) < duty);
            din = rnd ? 16'($urandom) : 16'(val);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; din = '0; in_valid = 1'b0; rate_log2 = 3'd3;
        do_reset(3'd3);
        chk_lit("reset_out", out_a, exp_a, 0);
        chk("reset_valid", vld_a, 0);
        chk("reset_err", err_a, 0);

        // DC gain, k=3: strobes 1..6 suppressed, 10 strobes in 80 samples -> 4 pulses
        pulse_cnt = 0;
        feed(80, 1000, 100, 0);
        feed(12, 0, 0, 0);
        chk_lit("dc_gain", out_a, exp_a, 1000);
        chk("dc_pulses", pulse_cnt, 4);

        // Rounding on the 12-bit instance, k=1 (s=8)
        do_reset(3'd1); feed(60, 1001, 100, 0); feed(10, 0, 0, 0);
        chk_lit("round_pos", out_b, exp_b, 63);
        do_reset(3'd1); feed(60, -1001, 100, 0); feed(10, 0, 0, 0);
        chk_lit("round_neg", out_b, exp_b, -63);

        // Saturation
        do_reset(3'd1); feed(40, 32767, 100, 0); feed(10, 0, 0, 0);
        chk_lit("sat_pos", out_b, exp_b, 2047);
        rate_log2 = 3'd5; feed(320, -32768, 100, 0); feed(20, 0, 0, 0);
        chk_lit("sat_neg", out_a, exp_a, -32768);

        // Rate change 3 -> 5 mid-stream
        do_reset(3'd3); feed(100, 0, 100, 1);
        rate_log2 = 3'd5; in_valid = 1'b1; din = 16'($urandom); tick();
        pulse_cnt = 0;
        feed(399, 0, 100, 1); feed(20, 0, 0, 0);
        chk("chg_pulses", pulse_cnt, 6);

        // Clamp: 7 acts as 5 (no restart), 0 acts as 1
        rate_log2 = 3'd7; feed(200, 0, 100, 1);
        chk("clamp_hi_err", err_a, 1);
        rate_log2 = 3'd0; feed(100, 0, 100, 1);
        chk("clamp_lo_err", err_a, 1);
        rate_log2 = 3'd1; feed(60, 0, 100, 1);

        // Gapped input at ~50% duty
        do_reset(3'd2); feed(300, 1000, 50, 0); feed(20, 0, 0, 0);
        chk_lit("gap_dc", out_a, exp_a, 1000);

        // Reset with strobes in flight
        do_reset(3'd1); feed(40, 0, 100, 1);
        reset = 1'b0; in_valid = 1'b1; tick(); reset = 1'b1; in_valid = 1'b0;
        chk("rst_mid_out", out_a, 0);
        chk("rst_mid_valid", vld_a, 0);
        feed(40, 0, 100, 1);

        // Random soak
        for (int seg = 0; seg < 40; seg++) begin
            if ($urandom_range(9) == 0) do_reset(3'($urandom));
            else if ($urandom_range(3) == 0) rate_log2 = 3'($urandom);
            feed(int'($urandom_range(150, 20)), 0, int'($urandom_range(100, 30)), 1);
        end
        feed(20, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
